ks_multiword_add_seq: RTL
=========================

// Module: ks_multiword_add_seq
// PURPOSE
//  Multi-precision add sequencer sitting directly upstream and downstream of kogge_stone_Nbit.
//  - Accepts one WORDS*BW-bit operand pair plus carry-in via valid/ready.
//  - Issues the operands to the adder one BW-bit word per step, LS word first.
//  - Chains each add_cout into the next word's add_cin.
//  - Collects the sum words and returns the full-width sum and final carry via valid/ready.
// PARAMETERS
//  BW       32  adder word width; must match the attached kogge_stone_Nbit bw.
//  WORDS    4   words per operand (>=1); operand width is WORDS*BW.
//  ADD_LAT  1   adder latency in clk cycles from add_a/add_b/add_cin to add_sum/add_cout (0 = combinational).
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-high reset
//  in_valid   in   1         operand pair valid
//  in_ready   out  1         sequencer can accept operands
//  in_a       in   WORDS*BW  operand A; word k = in_a[k*BW +: BW]
//  in_b       in   WORDS*BW  operand B
//  in_cin     in   1         carry into word 0
//  add_a      out  BW        word to adder port A
//  add_b      out  BW        word to adder port B
//  add_cin    out  1         carry to adder cin
//  add_sum    in   BW        adder sum
//  add_cout   in   1         adder cout
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  out_sum    out  WORDS*BW  full sum
//  out_cout   out  1         carry out of MS word
//  busy       out  1         high in RUN or DONE
// BEHAVIOUR
//  Reset (async, any state):
//  - state=IDLE; in_ready=1.
//  - out_valid, out_sum, out_cout, add_a, add_b, add_cin, busy = 0.
//  - Word index and latency counter = 0; an in-flight operation is discarded.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid & in_ready at edge T:
//    - Latch in_a and in_b.
//    - Drive add_a/add_b = word 0 and add_cin = in_cin.
//    - Set idx=0, cnt=0 and go to RUN.
//  - RUN: add_* are registered and held stable while word idx is in flight; cnt increments each cycle.
//    - At the edge where cnt==ADD_LAT: capture add_sum into out_sum word idx, and capture add_cout.
//    - If idx<WORDS-1: drive word idx+1 with add_cin = captured add_cout; set idx+1, cnt=0.
//    - Else: out_cout = add_cout, out_valid=1, go to DONE.
//  - DONE: out_valid=1; out_sum and out_cout held stable; in_ready=0.
//    - On out_valid & out_ready: out_valid=0 and go to IDLE.
//    - A new operand pair is accepted in the next IDLE cycle, at the earliest.
//  Timing:
//  - Each word takes ADD_LAT+1 cycles.
//  - out_valid rises WORDS*(ADD_LAT+1) cycles after the accept edge (default: 8).
//  Holds and constraints:
//  - In IDLE and DONE, add_a/add_b/add_cin hold their last values.
//  - in_a, in_b and in_cin are ignored outside the accept edge.
//  - in_ready = (state==IDLE); never combinationally dependent on out_ready.
//  - out_sum is modulo 2^(WORDS*BW); the carry exits only via out_cout. No saturation.
//  - With WORDS=1, a single issue goes straight to DONE.
//  - Simultaneous reset and handshake: reset wins.
// TESTING (BW=32, WORDS=4, ADD_LAT=1 unless noted; behavioural adder model with matching latency)
//  1. a=2^128-1, b=1, cin=0 -> out_sum=0, out_cout=1.
//     - Each add_cin for words 1..3 = 1.
//     - out_valid exactly 8 cycles after accept.
//  2. a=0, b=0, cin=1 -> out_sum=1, out_cout=0.
//     - add_cin = 0 for words 1..3.
//  3. a=0x0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, b=1, cin=0
//     -> out_sum=0x0000_0001_FFFF_FFFF_0000_0001_0000_0000, out_cout=0.
//  4. Hold out_ready=0 for 5 cycles after out_valid:
//     - out_valid, out_sum and out_cout stay stable; in_ready=0.
//     - in_valid is ignored until after the handshake.
//  5. Assert reset while word 2 is in flight:
//     - All outputs go to 0 immediately; in_ready=1.
//     - The next operation (case 1) completes correctly.
//  6. 1000 random back-to-back ops with in_valid and out_ready held high, run at ADD_LAT=0 and ADD_LAT=1
//     -> every result equals a+b+cin.
//     - Throughput is one result per WORDS*(ADD_LAT+1)+2 cycles.

Source files
------------

// File: rtl/ks_multiword_add_seq_if.sv
// Bundle of the operand, result and adder-side signals of the multi-word add sequencer.
// The slave modport is the sequencer's view; the master modport is its surroundings.
interface ks_multiword_add_seq_if #(
    parameter int BW    = 32,
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDS*BW-1:0]   in_a;
    logic [WORDS*BW-1:0]   in_b;
    logic                  in_cin;
    logic [BW-1:0]         add_a;
    logic [BW-1:0]         add_b;
    logic                  add_cin;
    logic [BW-1:0]         add_sum;
    logic                  add_cout;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORDS*BW-1:0]   out_sum;
    logic                  out_cout;
    logic                  busy;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
    );
endinterface

// File: rtl/ks_multiword_add_seq.sv
// Feeds a WORDS*BW-bit add through a BW-bit adder one word per step, LS word first,
// chaining the adder carry between words and returning the full sum plus final carry.
module ks_multiword_add_seq #(
    parameter int BW      = 32,
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 1
) (
    input logic                   clk,
    input logic                   reset,
    ks_multiword_add_seq_if.slave bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(ADD_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [WORDS*BW-1:0]   a_reg, a_next;
    logic [WORDS*BW-1:0]   b_reg, b_next;
    logic [WORDS*BW-1:0]   sum_reg, sum_next;
    logic                  cout_reg, cout_next;
    logic                  valid_reg, valid_next;
    logic [BW-1:0]         add_a_reg, add_a_next;
    logic [BW-1:0]         add_b_reg, add_b_next;
    logic                  add_cin_reg, add_cin_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [CW-1:0]         cnt_reg, cnt_next;

    logic [BW-1:0]         a_words [WORDS];
    logic [BW-1:0]         b_words [WORDS];
    logic [IW-1:0]         idx_inc;
    logic                  cnt_done;
    logic                  last_word;
    logic                  capture;

    assign idx_inc   = idx_reg + IW'(1);
    assign cnt_done  = (cnt_reg == CW'(ADD_LAT));
    assign last_word = (idx_reg == IW'(WORDS - 1));
    assign capture   = (state_reg == RUN) && cnt_done;

    // Each result word only updates on the step that owns it; all others hold.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign a_words[gi] = a_reg[gi*BW +: BW];
            assign b_words[gi] = b_reg[gi*BW +: BW];
            assign sum_next[gi*BW +: BW] = (capture && idx_reg == IW'(gi)) ?
                                           bus.add_sum : sum_reg[gi*BW +: BW];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
            add_cin_reg <= 1'b0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            sum_reg     <= sum_next;
            cout_reg    <= cout_next;
            valid_reg   <= valid_next;
            add_a_reg   <= add_a_next;
            add_b_reg   <= add_b_next;
            add_cin_reg <= add_cin_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        cout_next    = cout_reg;
        valid_next   = valid_reg;
        add_a_next   = add_a_reg;
        add_b_next   = add_b_reg;
        add_cin_next = add_cin_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next       = bus.in_a;
                    b_next       = bus.in_b;
                    add_a_next   = bus.in_a[BW-1:0];
                    add_b_next   = bus.in_b[BW-1:0];
                    add_cin_next = bus.in_cin;
                    idx_next     = '0;
                    cnt_next     = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (cnt_done) begin
                    if (!last_word) begin
                        add_a_next   = a_words[idx_inc];
                        add_b_next   = b_words[idx_inc];
                        add_cin_next = bus.add_cout;
                        idx_next     = idx_inc;
                        cnt_next     = '0;
                    end else begin
                        cout_next  = bus.add_cout;
                        valid_next = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.add_a     = add_a_reg;
    assign bus.add_b     = add_b_reg;
    assign bus.add_cin   = add_cin_reg;
    assign bus.out_valid = valid_reg;
    assign bus.out_sum   = sum_reg;
    assign bus.out_cout  = cout_reg;
endmodule
